digit_serial_addsub: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on both sides. Each operand pair is captured on acceptance and then processed DIGIT bits per clock, least significant digit first, with the carry held in a register between digits. The block replaces the fixed 4-bit combinational adder where area matters more than latency. It reports sum, unsigned carry/no-borrow, signed overflow and zero flags.

---
 rtl/digit_serial_addsub_if.sv | 28 ++
 rtl/digit_serial_addsub.sv | 123 ++++++++++++
 tb/tb_digit_serial_addsub.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_addsub_if.sv
// Operand/result bundle for digit_serial_addsub.
// Both sides use valid/ready: a transfer happens on the rising clk edge where valid and ready are both high.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per cycle, LSB digit first, with a registered carry between digits.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  digit_serial_addsub_if.slave bus,
  output logic [1:0]          state_dbg
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [SW-1:0]    step_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [31:0]      base;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_s;
  logic             chain_c;
  logic             dig_cmsb;
  logic             dig_cout;
  logic [WIDTH-1:0] sum_next;
  logic             last_step;

  // One DIGIT-bit ripple slice; dig_cmsb is the carry into the slice's top bit,
  // which on the final step is the carry into bit WIDTH-1.
  always_comb begin
    base     = 32'(step_q) * 32'(DIGIT);
    dig_a    = a_q[base +: DIGIT];
    dig_b    = b_q[base +: DIGIT];
    dig_s    = '0;
    chain_c  = carry_q;
    dig_cmsb = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dig_cmsb = chain_c;
      dig_s[i] = dig_a[i] ^ dig_b[i] ^ chain_c;
      chain_c  = (dig_a[i] & dig_b[i]) | (chain_c & (dig_a[i] ^ dig_b[i]));
    end
    dig_cout = chain_c;
    sum_next = sum_q;
    sum_next[base +: DIGIT] = dig_s;
    last_step = (step_q == SW'(NSTEP - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 rides in on the carry.
            a_q        <= bus.a;
            b_q        <= bus.sub ? ~bus.b : bus.b;
            carry_q    <= bus.sub;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          sum_q   <= sum_next;
          carry_q <= dig_cout;
          step_q  <= step_q + 1'b1;
          if (last_step) begin
            step_q      <= '0;
            cout_q      <= dig_cout;
            ovf_q       <= dig_cmsb ^ dig_cout;
            zero_q      <= (sum_next == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed checks on a 16/4 instance plus a random sweep on 8/1, 8/8 and 32/8 instances
// against a widened-arithmetic reference.
module tb_digit_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Main directed instance
  digit_serial_addsub_if #(.WIDTH(16), .DIGIT(4)) m_if ();
  logic [1:0] m_state;
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .bus(m_if.slave), .state_dbg(m_state)
  );

  // Sweep instances share one stimulus bus
  logic [31:0] s_a, s_b;
  logic        s_sub, s_in_valid, s_out_ready;

  digit_serial_addsub_if #(.WIDTH(8), .DIGIT(1))  w81_if ();
  digit_serial_addsub_if #(.WIDTH(8), .DIGIT(8))  w88_if ();
  digit_serial_addsub_if #(.WIDTH(32), .DIGIT(8)) w328_if ();
  logic [1:0] w81_st, w88_st, w328_st;

  assign w81_if.a = s_a[7:0];    assign w81_if.b = s_b[7:0];
  assign w81_if.sub = s_sub;     assign w81_if.in_valid = s_in_valid;
  assign w81_if.out_ready = s_out_ready;
  assign w88_if.a = s_a[7:0];    assign w88_if.b = s_b[7:0];
  assign w88_if.sub = s_sub;     assign w88_if.in_valid = s_in_valid;
  assign w88_if.out_ready = s_out_ready;
  assign w328_if.a = s_a;        assign w328_if.b = s_b;
  assign w328_if.sub = s_sub;    assign w328_if.in_valid = s_in_valid;
  assign w328_if.out_ready = s_out_ready;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) dut81 (
    .clk(clk), .rst(rst), .bus(w81_if.slave), .state_dbg(w81_st)
  );
  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut88 (
    .clk(clk), .rst(rst), .bus(w88_if.slave), .state_dbg(w88_st)
  );
  digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) dut328 (
    .clk(clk), .rst(rst), .bus(w328_if.slave), .state_dbg(w328_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, output logic [31:0] s,
                                    output logic c, output logic v, output logic z);
    logic [32:0] full;
    logic [31:0] mask, aa, bb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + 33'(sub);
    s    = full[31:0] & mask;
    c    = full[w];
    v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    z    = (s == 32'h0);
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] e_sum,
                        input logic e_c, input logic e_v, input logic e_z);
    int g;
    int lat;
    g = 0;
    while (!m_if.in_ready && g < 20) begin tick(); g++; end
    chk({tag, " in_ready"}, 64'(m_if.in_ready), 64'd1);
    m_if.a = a; m_if.b = b; m_if.sub = sub; m_if.in_valid = 1'b1;
    tick();
    m_if.in_valid = 1'b0;
    m_if.a = 16'($urandom); m_if.b = 16'($urandom); m_if.sub = ~sub;
    lat = 0;
    while (!m_if.out_valid && lat < 50) begin tick(); lat++; end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " sum"}, 64'(m_if.sum), 64'(e_sum));
    chk({tag, " carry_out"}, 64'(m_if.carry_out), 64'(e_c));
    chk({tag, " overflow"}, 64'(m_if.overflow), 64'(e_v));
    chk({tag, " zero"}, 64'(m_if.zero), 64'(e_z));
  endtask

  task automatic release_op(input string tag);
    m_if.out_ready = 1'b1;
    tick();
    m_if.out_ready = 1'b0;
    chk({tag, " out_valid after release"}, 64'(m_if.out_valid), 64'd0);
    chk({tag, " in_ready after release"}, 64'(m_if.in_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [31:0] op_a, op_b, e_s;
    logic        op_sub, e_c, e_v, e_z;
    int          lat81, lat88, lat328, cnt, g;

    m_if.in_valid = 1'b0; m_if.out_ready = 1'b0;
    m_if.a = '0; m_if.b = '0; m_if.sub = 1'b0;
    s_a = '0; s_b = '0; s_sub = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    chk("reset state", 64'(m_state), 64'd0);
    chk("reset in_ready", 64'(m_if.in_ready), 64'd0);
    chk("reset out_valid", 64'(m_if.out_valid), 64'd0);
    chk("reset sum", 64'(m_if.sum), 64'd0);
    chk("reset flags", 64'({m_if.carry_out, m_if.overflow, m_if.zero}), 64'd0);
    rst = 1'b0;
    tick();
    chk("in_ready after reset", 64'(m_if.in_ready), 64'd1);

    // Directed arithmetic
    run_op("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    release_op("add 7fff+1");
    run_op("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_op("add ffff+1");
    run_op("sub 5-7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    release_op("sub 5-7");
    run_op("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    release_op("sub 8000-1");
    run_op("sub 1234-1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_op("sub 1234-1234");
    run_op("sub 0-8000", 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    release_op("sub 0-8000");

    // Backpressure: outputs hold, nothing new accepted
    run_op("bp 1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      m_if.in_valid = i[0];
      m_if.a = 16'($urandom); m_if.b = 16'($urandom); m_if.sub = i[1];
      tick();
      chk("bp out_valid held", 64'(m_if.out_valid), 64'd1);
      chk("bp in_ready low", 64'(m_if.in_ready), 64'd0);
      chk("bp outputs held", 64'({m_if.sum, m_if.carry_out, m_if.overflow, m_if.zero}),
          64'({16'h5555, 3'b000}));
    end
    m_if.in_valid = 1'b0;
    release_op("bp");
    chk("bp state idle", 64'(m_state), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); seen = seen | m_if.out_valid; end
    chk("bp no extra op", 64'(seen), 64'd0);

    // Reset during the second BUSY cycle
    m_if.a = 16'hAAAA; m_if.b = 16'h1111; m_if.sub = 1'b0; m_if.in_valid = 1'b1;
    tick();
    m_if.in_valid = 1'b0;
    tick();
    chk("abort in busy", 64'(m_state), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort state", 64'(m_state), 64'd0);
    chk("abort outputs", 64'({m_if.sum, m_if.carry_out, m_if.overflow, m_if.zero,
                              m_if.out_valid, m_if.in_ready}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen = seen | m_if.out_valid; end
    chk("abort no out_valid", 64'(seen), 64'd0);
    run_op("post abort 1234+1111", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    release_op("post abort");

    // Parameter sweep
    for (int op = 0; op < 1000; op++) begin
      g = 0;
      while (!(w81_if.in_ready && w88_if.in_ready && w328_if.in_ready) && g < 20) begin
        tick(); g++;
      end
      chk("sweep in_ready", 64'(w81_if.in_ready & w88_if.in_ready & w328_if.in_ready), 64'd1);
      op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom_range(0, 1));
      if (op % 16 == 0) op_b = op_a;
      if (op % 16 == 1) op_b = ~op_a;
      if (op % 16 == 2) begin op_a = 32'h7F7F_7F7F; op_b = 32'h0101_0101; end
      if (op % 16 == 3) begin op_a = 32'h8080_8080; op_b = 32'h0101_0101; end
      s_a = op_a; s_b = op_b; s_sub = op_sub; s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0; s_a = $urandom; s_b = $urandom; s_sub = ~op_sub;
      lat81 = -1; lat88 = -1; lat328 = -1; cnt = 0;
      while ((lat81 < 0 || lat88 < 0 || lat328 < 0) && cnt < 50) begin
        tick(); cnt++;
        if (lat81 < 0 && w81_if.out_valid) lat81 = cnt;
        if (lat88 < 0 && w88_if.out_valid) lat88 = cnt;
        if (lat328 < 0 && w328_if.out_valid) lat328 = cnt;
      end
      chk("w8d1 latency", 64'(lat81), 64'd8);
      chk("w8d8 latency", 64'(lat88), 64'd1);
      chk("w32d8 latency", 64'(lat328), 64'd4);

      ref_model(8, op_a, op_b, op_sub, e_s, e_c, e_v, e_z);
      chk("w8d1 sum", 64'(w81_if.sum), 64'(e_s[7:0]));
      chk("w8d1 flags", 64'({w81_if.carry_out, w81_if.overflow, w81_if.zero}),
          64'({e_c, e_v, e_z}));
      chk("w8d8 sum", 64'(w88_if.sum), 64'(e_s[7:0]));
      chk("w8d8 flags", 64'({w88_if.carry_out, w88_if.overflow, w88_if.zero}),
          64'({e_c, e_v, e_z}));
      ref_model(32, op_a, op_b, op_sub, e_s, e_c, e_v, e_z);
      chk("w32d8 sum", 64'(w328_if.sum), 64'(e_s));
      chk("w32d8 flags", 64'({w328_if.carry_out, w328_if.overflow, w328_if.zero}),
          64'({e_c, e_v, e_z}));

      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
